// File: rtl/instr_encoder_loader.sv
`default_nettype none
// instr_encoder_loader: packs instruction field tuples into 14-bit words and writes them
// sequentially into instruction memory. Optional macro: FIELD_CHECK_EN. Revision: 1.0
module instr_encoder_loader #(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_count,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [1:0]        i_reg0_addr,
  input  logic [1:0]        i_reg1_addr,
  input  logic [1:0]        i_reg2_addr,
  input  logic [3:0]        i_reserved,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [13:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              accept;
  logic              beat_ok;
  logic [13:0]       word;

  assign accept = i_valid && o_ready;
  assign word   = {i_opcode, i_reg0_addr, i_reg1_addr, i_reg2_addr, i_reserved};

`ifdef FIELD_CHECK_EN
  assign beat_ok = (i_reserved == 4'h0);
`else
  assign beat_ok = 1'b1;
`endif

  assign o_ready = (state == ST_LOAD);
  assign o_busy  = (state == ST_LOAD);
  assign o_done  = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr         <= '0;
      remaining    <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_error      <= 1'b0;
    end else begin
      o_imem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_error <= (i_count > DEPTH);
            if ((i_count == '0) || (i_count > DEPTH)) begin
              state <= ST_DONE;
            end else begin
              addr      <= i_base_addr;
              remaining <= i_count;
              state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            remaining <= remaining - CNT_ONE;
            // A rejected beat still consumes a slot but leaves the address in place.
            if (beat_ok) begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= addr;
              o_imem_wdata <= word;
              addr         <= addr + ADDR_ONE;
            end else begin
              o_error <= 1'b1;
            end
            if (remaining == CNT_ONE) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// Directed self-checking bench for instr_encoder_loader.
module tb_instr_encoder_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [3:0] i_base_addr;
  logic [4:0] i_count;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_opcode;
  logic [1:0] i_reg0_addr, i_reg1_addr, i_reg2_addr;
  logic [3:0] i_reserved;
  logic       o_imem_we;
  logic [3:0] o_imem_addr;
  logic [13:0] o_imem_wdata;
  logic       o_busy, o_done, o_error;

  int errors = 0;
  int checks = 0;

  // {ready, we, busy, done, error, addr, wdata}
  logic [22:0] obs;
  logic [22:0] exp;
  logic [4:0]  flags;
  logic [4:0]  exp_flags;
  assign obs   = {o_ready, o_imem_we, o_busy, o_done, o_error, o_imem_addr, o_imem_wdata};
  assign flags = {o_ready, o_imem_we, o_busy, o_done, o_error};

  instr_encoder_loader #(.IMEM_DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_count(i_count), .i_valid(i_valid), .o_ready(o_ready), .i_opcode(i_opcode),
    .i_reg0_addr(i_reg0_addr), .i_reg1_addr(i_reg1_addr), .i_reg2_addr(i_reg2_addr),
    .i_reserved(i_reserved), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] op, input logic [1:0] r0, input logic [1:0] r1,
                          input logic [1:0] r2, input logic [3:0] res);
    i_valid = 1'b1; i_opcode = op; i_reg0_addr = r0; i_reg1_addr = r1;
    i_reg2_addr = r2; i_reserved = res;
  endtask

  task automatic start(input logic [3:0] base, input logic [4:0] cnt);
    i_start = 1'b1; i_base_addr = base; i_count = cnt;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, exp); end
    reset = 1'b0; tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL idle_after_reset: got %h expected %h", obs, exp); end
  endtask

  task automatic test_mid_reset();
    start(4'd1, 5'd3);
    set_beat(4'h6, 2'd2, 2'd1, 2'd3, 4'h0);
    tick();
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 14'h1A70}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_beat1: got %h expected %h", obs, exp); end
    reset = 1'b1;
    tick();
    exp = '0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_reset: got %h expected %h", obs, exp); end
    reset = 1'b0; i_valid = 1'b0;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_after: got %h expected %h", obs, exp); end
  endtask

  task automatic test_basic();
    start(4'd2, 5'd3);
    exp_flags = 5'b10100; checks++;
    if (flags !== exp_flags) begin errors++; $display("FAIL basic_load: got %b expected %b", flags, exp_flags); end
    set_beat(4'h1, 2'd0, 2'd1, 2'd2, 4'h0); tick();
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 14'h0460}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_w1: got %h expected %h", obs, exp); end
    set_beat(4'hA, 2'd3, 2'd2, 2'd1, 4'h0); tick();
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 14'h2B90}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_w2: got %h expected %h", obs, exp); end
    set_beat(4'hF, 2'd1, 2'd1, 2'd1, 4'h0); tick();
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 14'h3D50}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_w3_done: got %h expected %h", obs, exp); end
    i_valid = 1'b0; tick();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 14'h3D50}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL basic_hold: got %h expected %h", obs, exp); end
  endtask

  task automatic test_wrap();
    start(4'd15, 5'd2);
    set_beat(4'h7, 2'd0, 2'd0, 2'd0, 4'h0); tick();
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 14'h1C00}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL wrap_w15: got %h expected %h", obs, exp); end
    set_beat(4'h8, 2'd1, 2'd0, 2'd0, 4'h0); tick();
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 14'h2100}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL wrap_w0: got %h expected %h", obs, exp); end
    i_valid = 1'b0; tick(); tick();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 14'h2100}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL wrap_busy_low: got %h expected %h", obs, exp); end
  endtask

  task automatic test_backpressure();
    start(4'd5, 5'd2);
    set_beat(4'h3, 2'd1, 2'd2, 2'd3, 4'h0); tick();
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 14'h0DB0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_w1: got %h expected %h", obs, exp); end
    i_valid = 1'b0; tick();
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 14'h0DB0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_gap1: got %h expected %h", obs, exp); end
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_gap2: got %h expected %h", obs, exp); end
    set_beat(4'h4, 2'd0, 2'd0, 2'd0, 4'h0); tick();
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 14'h1000}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_w2: got %h expected %h", obs, exp); end
    set_beat(4'h9, 2'd3, 2'd3, 2'd3, 4'h0); tick();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 14'h1000}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_not_consumed: got %h expected %h", obs, exp); end
    i_valid = 1'b0;
  endtask

  task automatic test_errors();
    start(4'd0, 5'd17);
    exp_flags = 5'b00011; checks++;
    if (flags !== exp_flags) begin errors++; $display("FAIL err17_done: got %b expected %b", flags, exp_flags); end
    tick();
    exp_flags = 5'b00001; checks++;
    if (flags !== exp_flags) begin errors++; $display("FAIL err17_sticky: got %b expected %b", flags, exp_flags); end
    start(4'd0, 5'd0);
    exp_flags = 5'b00010; checks++;
    if (flags !== exp_flags) begin errors++; $display("FAIL cnt0_done_clear: got %b expected %b", flags, exp_flags); end
    tick();
    exp_flags = 5'b00000; checks++;
    if (flags !== exp_flags) begin errors++; $display("FAIL cnt0_idle: got %b expected %b", flags, exp_flags); end
  endtask

  task automatic test_full_depth();
    logic [3:0] a;
    start(4'd0, 5'd16);
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      i_start = (i < 15); i_count = 5'd0;
      set_beat(a, 2'd0, 2'd0, 2'd0, 4'h0); tick();
      exp = {(i < 15), 1'b1, (i < 15), (i == 15), 1'b0, a, {a, 10'h000}}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL full_w%0d: got %h expected %h", i, obs, exp); end
    end
    i_start = 1'b0; i_valid = 1'b0; tick();
  endtask

`ifdef FIELD_CHECK_EN
  task automatic test_field_check();
    start(4'd7, 5'd2);
    set_beat(4'h9, 2'd1, 2'd1, 2'd1, 4'h3); tick();
    exp_flags = 5'b10101; checks++;
    if (flags !== exp_flags) begin errors++; $display("FAIL fc_reject: got %b expected %b", flags, exp_flags); end
    set_beat(4'h5, 2'd1, 2'd2, 2'd3, 4'h0); tick();
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 14'h15B0}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL fc_write: got %h expected %h", obs, exp); end
    i_valid = 1'b0; tick();
  endtask
`else
  task automatic test_field_check();
    start(4'd9, 5'd1);
    set_beat(4'h2, 2'd3, 2'd0, 2'd1, 4'h9); tick();
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 14'h0B19}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reserved_verbatim: got %h expected %h", obs, exp); end
    i_valid = 1'b0; tick();
  endtask
`endif

  initial begin
    reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_count = '0; i_valid = 1'b0;
    i_opcode = '0; i_reg0_addr = '0; i_reg1_addr = '0; i_reg2_addr = '0; i_reserved = '0;
    test_reset();
    test_mid_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_errors();
    test_full_depth();
    test_field_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
